cdma_tx_scheduler: RTL and testbench
====================================

Name: cdma_tx_scheduler

Overview:
- Time-shares one `cdma_transmitter` spreader between two user data sources.
- Accepts one data bit per user over a valid/ready handshake.
- Arbitrates round-robin when both users request.
- Holds the granted bit and user select on the spreader inputs for exactly CHIPS_PER_BIT chip cycles, with symbol framing pulses.
- Sits between the per-user bit sources and the spreader's `data_in` / `user_select` inputs.

Parameters:
- CHIPS_PER_BIT, 6: chips spread per data bit, matching the 6-bit user codes; legal range 2..64.
- CNT_W, $clog2(CHIPS_PER_BIT): chip counter width; derived, not overridden.

Ports:
- clk  in  1  system/chip clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sched_en  in  1  1 = new grants allowed; 0 = finish current bit, then idle
- u_valid  in  2  per-user bit available; [0]=user1, [1]=user2
- u_data  in  2  per-user data bit; stable while valid
- u_ready  out  2  per-user accept, combinational; at most one bit high
- tx_en  out  1  spreader output qualifier, high during every chip of a bit
- tx_data  out  1  bit to spreader `data_in`
- tx_user_sel  out  1  to spreader `user_select`; 0=user1, 1=user2
- bit_start  out  1  one-cycle pulse on chip 0 of a bit
- bit_done  out  1  one-cycle pulse on chip CHIPS_PER_BIT-1 of a bit
- chip_idx  out  CNT_W  current chip index, 0..CHIPS_PER_BIT-1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, chip_cnt=0, last_grant=1 (user1 wins the first tie).
  - All outputs 0: tx_en, tx_data, tx_user_sel, bit_start, bit_done, chip_idx, u_ready.
  - A bit in flight is dropped and never re-issued.
- States:
  - IDLE: tx_en=0.
  - SPREAD: tx_en=1, tx_data and tx_user_sel held constant.
- Accept window: asserted when sched_en=1 and (state==IDLE, or state==SPREAD with chip_cnt==CHIPS_PER_BIT-1).
- Arbitration inside the accept window:
  - Only one valid user: that user wins.
  - Both valid: the user != last_grant wins.
  - u_ready[winner]=1 in that cycle; the other bit stays 0.
  - Transfer is u_valid[i] & u_ready[i].
- On transfer:
  - Next cycle: state=SPREAD, chip_cnt=0, tx_data=u_data[i], tx_user_sel=i, last_grant=i, bit_start=1.
  - Latency is 1 cycle from handshake to chip 0.
- In SPREAD:
  - chip_cnt increments by 1 per cycle; chip_idx=chip_cnt.
  - bit_done=1 when chip_cnt==CHIPS_PER_BIT-1.
- Leaving the last chip:
  - With a transfer in the same cycle: back-to-back, the next cycle is chip 0 of the new bit with no gap.
  - Otherwise: next state IDLE, tx_en=0, tx_data and tx_user_sel keep their last values, chip_idx=0.
- sched_en deasserted mid-bit: the current bit completes all CHIPS_PER_BIT chips, then the block goes IDLE. u_ready stays 0 while sched_en=0.
- u_valid deasserted mid-bit: no effect on the bit in flight.
- Counter never exceeds CHIPS_PER_BIT-1. No wrap is observable except through the back-to-back reload to 0.
- A bit is not spread until at least 1 cycle after reset deasserts.

Optional Feature:
- Macro: CDMA_SCHED_STATS_EN.
- Defined:
  - Adds outputs `bits_sent_u1` and `bits_sent_u2`, each 16 bits, reset to 0.
  - Each counter increments on bit_done for the matching tx_user_sel and wraps 0xFFFF→0.
  - Adds output `idle_cycles`, 16 bits, saturating at 0xFFFF; counts cycles with state==IDLE and sched_en=1.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset: rst=1 with u_valid=2'b11 → all outputs 0 and u_ready=2'b00. Release rst and set sched_en=1 → u_ready=2'b01 in the first cycle, bit_start on the next cycle with tx_user_sel=0.
2. Single user: u_valid=2'b10, u_data[1]=1 → tx_en high for exactly 6 cycles, tx_data=1, tx_user_sel=1, chip_idx 0..5, bit_start at chip 0, bit_done at chip 5, then IDLE.
3. Contention: u_valid=2'b11 held for 4 bits → grants alternate 0,1,0,1. tx_en stays high for 24 consecutive cycles, with bit_start every 6 cycles.
4. Back-to-back and gap: user1 valid only on the last chip → next bit starts with no gap. User1 valid 1 cycle after the last chip → 1 IDLE cycle with tx_en=0, then chip 0.
5. sched_en dropped at chip 2 → chips 3..5 still emitted, then IDLE with u_ready=0 while valid=1. Raising sched_en → grant on that cycle.
6. rst asserted at chip 3 → outputs 0 asynchronously, before the next clock edge. After release, the dropped bit is not resumed, and the first grant goes to user1 (last_grant=1). With CDMA_SCHED_STATS_EN defined, bits_sent_u1=2 and bits_sent_u2=2 after scenario 3.

Source files
------------

// File: rtl/cdma_tx_scheduler.sv
// cdma_tx_scheduler: round-robin two-user bit scheduler feeding one CDMA spreader.
// Optional per-user bit counters and idle counter via macro CDMA_SCHED_STATS_EN.
module cdma_tx_scheduler #(
   parameter  int CHIPS_PER_BIT = 6,
   localparam int CNT_W = $clog2(CHIPS_PER_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sched_en,
   input  logic [1:0]       u_valid,
   input  logic [1:0]       u_data,
   output logic [1:0]       u_ready,
   output logic             tx_en,
   output logic             tx_data,
   output logic             tx_user_sel,
   output logic             bit_start,
   output logic             bit_done,
   output logic [CNT_W-1:0] chip_idx
`ifdef CDMA_SCHED_STATS_EN
   ,
   output logic [15:0]      bits_sent_u1,
   output logic [15:0]      bits_sent_u2,
   output logic [15:0]      idle_cycles
`endif
);
   typedef enum logic {IDLE, SPREAD} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] chip_q;
   logic             last_q, data_q, sel_q, start_q;
   logic             last_chip, window, win_d, xfer;

   assign last_chip   = chip_q == CNT_W'(CHIPS_PER_BIT - 1);
   assign tx_en       = state_q == SPREAD;
   assign tx_data     = data_q;
   assign tx_user_sel = sel_q;
   assign bit_start   = start_q;
   assign bit_done    = (state_q == SPREAD) && last_chip;
   assign chip_idx    = chip_q;

   // Accept window and round-robin winner; ready is forced low while reset is held.
   always_comb begin
      window  = sched_en && !rst && (state_q == IDLE || last_chip);
      win_d   = (&u_valid) ? ~last_q : u_valid[1];
      xfer    = window && (|u_valid);
      u_ready = xfer ? (win_d ? 2'b10 : 2'b01) : 2'b00;
   end

   // Bit framing FSM: load on transfer, count chips, drop to IDLE after the last chip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         chip_q  <= '0;
         last_q  <= 1'b1;
         data_q  <= 1'b0;
         sel_q   <= 1'b0;
         start_q <= 1'b0;
      end else if (xfer) begin
         state_q <= SPREAD;
         chip_q  <= '0;
         data_q  <= u_data[win_d];
         sel_q   <= win_d;
         last_q  <= win_d;
         start_q <= 1'b1;
      end else begin
         start_q <= 1'b0;
         if (state_q == SPREAD) begin
            state_q <= last_chip ? IDLE : SPREAD;
            chip_q  <= last_chip ? '0 : chip_q + CNT_W'(1);
         end
      end
   end

`ifdef CDMA_SCHED_STATS_EN
   logic [15:0] sent1_q, sent2_q, idle_q;
   assign bits_sent_u1 = sent1_q;
   assign bits_sent_u2 = sent2_q;
   assign idle_cycles  = idle_q;

   // Wrapping per-user completed-bit counters and a saturating enabled-idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sent1_q <= '0;
         sent2_q <= '0;
         idle_q  <= '0;
      end else begin
         if (bit_done && !sel_q) sent1_q <= sent1_q + 16'd1;
         if (bit_done && sel_q) sent2_q <= sent2_q + 16'd1;
         if (state_q == IDLE && sched_en && idle_q != 16'hFFFF) idle_q <= idle_q + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cdma_tx_scheduler.sv
// tb_cdma_tx_scheduler: directed and randomized checks of cdma_tx_scheduler against a transaction-level model.
module tb_cdma_tx_scheduler;
   localparam int N  = 6;
   localparam int CW = $clog2(N);

   logic          clk, rst, sched_en;
   logic [1:0]    u_valid, u_data, u_ready;
   logic          tx_en, tx_data, tx_user_sel, bit_start, bit_done;
   logic [CW-1:0] chip_idx;
`ifdef CDMA_SCHED_STATS_EN
   logic [15:0]   bits_sent_u1, bits_sent_u2, idle_cycles;
`endif

   int checks = 0;
   int failures = 0;

   cdma_tx_scheduler #(.CHIPS_PER_BIT(N)) dut (
      .clk(clk), .rst(rst), .sched_en(sched_en), .u_valid(u_valid), .u_data(u_data),
      .u_ready(u_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_user_sel(tx_user_sel),
      .bit_start(bit_start), .bit_done(bit_done), .chip_idx(chip_idx)
`ifdef CDMA_SCHED_STATS_EN
      , .bits_sent_u1(bits_sent_u1), .bits_sent_u2(bits_sent_u2), .idle_cycles(idle_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [CW+6:0] obs = {u_ready, tx_en, tx_data, tx_user_sel, bit_start, bit_done, chip_idx};

   // Model: the bit in flight is (m_user, m_data) at chip m_chip, or m_chip=-1 when nothing is being spread.
   int   m_chip;
   logic m_user, m_data, m_last;
   logic [15:0] m_s1, m_s2;
   int   m_idle;

   function automatic void m_reset();
      m_chip = -1; m_user = 0; m_data = 0; m_last = 1;
      m_s1 = 0; m_s2 = 0; m_idle = 0;
   endfunction

   function automatic logic [1:0] m_ready();
      if (!sched_en || !(m_chip < 0 || m_chip == N - 1) || u_valid == 2'b00) return 2'b00;
      if (u_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
      return u_valid;
   endfunction

   function automatic logic [CW+6:0] exp_vec();
      int c;
      c = (m_chip < 0) ? 0 : m_chip;
      return {m_ready(), m_chip >= 0, m_data, m_user, m_chip == 0, m_chip == N - 1, CW'(c)};
   endfunction

   function automatic void m_tick();
      logic [1:0] r;
      r = m_ready();
      if (m_chip == N - 1) begin
         if (m_user) m_s2 = m_s2 + 16'd1; else m_s1 = m_s1 + 16'd1;
      end
      if (m_chip < 0 && sched_en && m_idle < 65535) m_idle++;
      if (r != 2'b00) begin
         m_user = r[1];
         m_data = u_data[r[1]];
         m_last = r[1];
         m_chip = 0;
      end else if (m_chip >= 0) begin
         m_chip = (m_chip == N - 1) ? -1 : m_chip + 1;
      end
   endfunction

   // Drive inputs just after a rising edge, then wait to the falling edge for sampling.
   task automatic cyc(input logic s, input logic [1:0] v, input logic [1:0] d);
      sched_en = s; u_valid = v; u_data = d;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      m_tick();
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sched_en = 1'b0; u_valid = 2'b11; u_data = 2'b11;
      m_reset();
      #3;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", obs); end
      sched_en = 1'b1;
      #1;
      checks++;
      if (u_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", u_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, (i == 0) ? 2'b11 : 2'b00, 2'b10);
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL reset_release cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         if (i == 0) begin
            checks++;
            if (u_ready !== 2'b01) begin failures++; $display("FAIL first_grant got=%b exp=01", u_ready); end
         end
         if (i == 1) begin
            checks++;
            if ({bit_start, tx_user_sel} !== 2'b10) begin failures++; $display("FAIL first_start got=%b exp=10", {bit_start, tx_user_sel}); end
         end
         adv();
      end
   endtask

   task automatic test_single();
      int en_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, (i == 0) ? 2'b10 : 2'b00, 2'b10);
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL single cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         en_cnt += int'(tx_en);
         adv();
      end
      checks++;
      if (en_cnt != N) begin failures++; $display("FAIL single_len got=%0d exp=%0d", en_cnt, N); end
   endtask

   task automatic test_contention();
      int en_cnt = 0, st_cnt = 0;
      do_reset();
      for (int i = 0; i < 26; i++) begin
         cyc(1'b1, (i < 19) ? 2'b11 : 2'b00, 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL contention cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         en_cnt += int'(tx_en);
         st_cnt += int'(bit_start);
         adv();
      end
      checks++;
      if (en_cnt != 4 * N || st_cnt != 4) begin failures++; $display("FAIL contention_len got=%0d/%0d exp=%0d/4", en_cnt, st_cnt, 4 * N); end
`ifdef CDMA_SCHED_STATS_EN
      checks++;
      if (bits_sent_u1 !== 16'd2 || bits_sent_u2 !== 16'd2) begin
         failures++; $display("FAIL stats_contention got=%0d,%0d exp=2,2", bits_sent_u1, bits_sent_u2);
      end
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 22; i++) begin
         cyc(1'b1, (i == 0 || i == N || i == 2 * N + 1) ? 2'b01 : 2'b00, 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL b2b cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         if (i == N + 1 || i == 2 * N + 1) begin
            checks++;
            if (tx_en !== (i == N + 1)) begin failures++; $display("FAIL b2b_gap cyc%0d got=%b exp=%b", i, tx_en, i == N + 1); end
         end
         adv();
      end
   endtask

   task automatic test_sched_en();
      for (int i = 0; i < 14; i++) begin
         cyc(!(i >= 3 && i < 10), (i == 0) ? 2'b01 : 2'b11, 2'b01);
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL sched_en cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         adv();
      end
      cyc(1'b1, 2'b00, 2'b00);
      for (int i = 0; i < N; i++) adv();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, (i == 0) ? 2'b10 : 2'b00, 2'b10);
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL areset_pre cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         if (i < 4) adv();
      end
      u_valid = 2'b11;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL areset_async got=%b exp=0", obs); end
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, (i == 0) ? 2'b11 : 2'b00, 2'b01);
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL areset_post cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
         if (i == 0) begin
            checks++;
            if (u_ready !== 2'b01) begin failures++; $display("FAIL areset_grant got=%b exp=01", u_ready); end
         end
         adv();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== exp_vec()) begin failures++; $display("FAIL random cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
`ifdef CDMA_SCHED_STATS_EN
         checks++;
         if (bits_sent_u1 !== m_s1 || bits_sent_u2 !== m_s2 || idle_cycles !== 16'(m_idle)) begin
            failures++;
            $display("FAIL random_stats cyc%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i,
                     bits_sent_u1, bits_sent_u2, idle_cycles, m_s1, m_s2, m_idle);
         end
`endif
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_sched_en();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
